// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shifter and sticky EQ/LT flags (in_* request, out_* result, flag_* last compare)
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             flag_eq,
  output logic             flag_lt
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [LW:0] STEP = (LW+1)'(SHIFT_STEP);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] acc, res;
  logic [WIDTH:0] usum;
  logic [LW-1:0] rem, n;
  logic [LW:0] rem_x, s, rem_n;
  logic [2:0] sop;
  logic err_q, err, cmp, eq, lt, is_shift, go_shift, accept, last;
  function automatic logic [WIDTH-1:0] shf(input logic [2:0] k, input logic [WIDTH-1:0] x, input logic [LW:0] d);
    logic [2*WIDTH-1:0] r, l;
    logic [WIDTH-1:0] sa;
    r = {x, x} >> d;
    l = {x, x} << d;
    sa = $signed(x) >>> d;
    return k == 3'd0 ? x >> d : k == 3'd1 ? x << d : k == 3'd2 ? sa :
           k == 3'd4 ? r[WIDTH-1:0] : l[2*WIDTH-1:WIDTH];
  endfunction
  always_comb begin
    usum = {1'b0, in_a} + {1'b0, in_b};
    res = '0;
    err = 1'b0;
    cmp = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    is_shift = 1'b0;
    case (in_op)
      6'h00: res = in_a + in_b;
      6'h01: res = in_a & in_b;
      6'h02: res = in_a | in_b;
      6'h03: res = in_a ^ in_b;
      6'h04: res = in_a - in_b;
      6'h05: res = in_a & ~in_b;
      6'h06: res = in_a | ~in_b;
      6'h07: res = in_a ^ ~in_b;
      6'h10, 6'h11, 6'h12, 6'h14, 6'h15: begin
        is_shift = 1'b1;
        res = in_a;
      end
      6'h20: begin
        cmp = 1'b1;
        res = usum[WIDTH-1:0];
        eq = res == '0;
        lt = $signed({in_a[WIDTH-1], in_a}) < -$signed({in_b[WIDTH-1], in_b});
      end
      6'h21: begin
        cmp = 1'b1;
        res = usum[WIDTH-1:0];
        eq = res == '0;
        lt = !usum[WIDTH];
      end
      6'h22, 6'h26: begin
        cmp = 1'b1;
        res = in_a & (in_op[2] ? ~in_b : in_b);
        eq = res == '0;
        lt = res[WIDTH-1];
      end
      6'h24, 6'h25: begin
        cmp = 1'b1;
        res = in_a - in_b;
        eq = in_a == in_b;
        lt = in_op[0] ? in_a < in_b : $signed(in_a) < $signed(in_b);
      end
      default: err = 1'b1;
    endcase
  end
  assign n = in_b[LW-1:0];
  assign go_shift = is_shift && n != '0;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign rem_x = {1'b0, rem};
  assign s = rem_x > STEP ? STEP : rem_x;
  assign rem_n = rem_x - s;
  assign last = rem_n == '0;
  assign out_valid = state == DONE;
  assign out_result = acc;
  assign out_err = err_q;
  always_comb begin
    state_d = state;
    if (accept) state_d = go_shift ? SHIFT : DONE;
    else if (state == SHIFT) state_d = last ? DONE : SHIFT;
    else if (state == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      rem <= '0;
      sop <= '0;
      err_q <= 1'b0;
      flag_eq <= 1'b0;
      flag_lt <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        acc <= res;
        rem <= n;
        sop <= in_op[2:0];
        err_q <= err;
        if (cmp) begin
          flag_eq <= eq;
          flag_lt <= lt;
        end
      end else if (state == SHIFT) begin
        acc <= shf(sop, acc, s);
        rem <= rem_n[LW-1:0];
      end
    end
  end
endmodule
